// File: rtl/alarm_snooze_ctrl.sv
// Alarm responder: owns the buzzer, handles snooze/dismiss, ring timeout and re-arm.
// Optional per-event snooze limit enabled by defining SNOOZE_LIMIT_EN.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_SEC = 540,
  parameter int RING_SEC   = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int SW = $clog2(SNOOZE_SEC + 1),
  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          alarm_on,
  input  logic          alarm_match,
  input  logic          snooze_btn,
  input  logic          dismiss_btn,
  output logic          buzz,
  output logic          snoozing,
  output logic [SW-1:0] snooze_left
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] ring, ring_n;
  logic [SW-1:0] left_n;
  logic          snz_q, dis_q;
  logic          snz_p, dis_p;
  logic          snz_ok;

  assign snz_p = snooze_btn & ~snz_q;
  assign dis_p = dismiss_btn & ~dis_q;

`ifdef SNOOZE_LIMIT_EN
  localparam int CW = $clog2(MAX_SNOOZE + 1);
  logic [CW-1:0] cnt, cnt_n;

  assign snz_ok = (cnt != CW'(MAX_SNOOZE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_n;
  end
`else
  assign snz_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    ring_n  = ring;
    left_n  = snooze_left;
`ifdef SNOOZE_LIMIT_EN
    cnt_n   = cnt;
`endif
    if (!alarm_on) begin
      state_n = IDLE;
      ring_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          ring_n = '0;
          if (alarm_match) state_n = RING;
        end
        RING: begin
          if (dis_p) begin
            state_n = DONE;
          end else if (snz_p) begin
            // a refused snooze press still swallows a coincident tick
            if (snz_ok) begin
              state_n = SNOOZE;
              left_n  = SW'(SNOOZE_SEC);
`ifdef SNOOZE_LIMIT_EN
              cnt_n   = cnt + 1'b1;
`endif
            end
          end else if (tick) begin
            if (ring == RW'(RING_SEC - 1)) state_n = DONE;
            else                           ring_n  = ring + 1'b1;
          end
        end
        SNOOZE: begin
          if (dis_p) begin
            state_n = DONE;
          end else if (!snz_p && tick) begin
            if (snooze_left <= SW'(1)) begin
              state_n = RING;
              ring_n  = '0;
            end else begin
              left_n = snooze_left - 1'b1;
            end
          end
        end
        DONE: begin
          if (!alarm_match) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    if (state_n != SNOOZE) left_n = '0;
`ifdef SNOOZE_LIMIT_EN
    if (state_n == IDLE) cnt_n = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ring        <= '0;
      snz_q       <= 1'b0;
      dis_q       <= 1'b0;
      buzz        <= 1'b0;
      snoozing    <= 1'b0;
      snooze_left <= '0;
    end else begin
      state       <= state_n;
      ring        <= ring_n;
      snz_q       <= snooze_btn;
      dis_q       <= dismiss_btn;
      buzz        <= (state_n == RING);
      snoozing    <= (state_n == SNOOZE);
      snooze_left <= left_n;
    end
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl: vector table plus corner sequences.
// Snooze-limit checks follow SNOOZE_LIMIT_EN when defined.
module tb_alarm_snooze_ctrl;

  localparam int SNOOZE_SEC = 5;
  localparam int RING_SEC   = 4;
  localparam int MAX_SNOOZE = 2;
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          alarm_on;
  logic          alarm_match;
  logic          snooze_btn;
  logic          dismiss_btn;
  logic          buzz;
  logic          snoozing;
  logic [SW-1:0] snooze_left;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC(SNOOZE_SEC),
    .RING_SEC  (RING_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .alarm_on   (alarm_on),
    .alarm_match(alarm_match),
    .snooze_btn (snooze_btn),
    .dismiss_btn(dismiss_btn),
    .buzz       (buzz),
    .snoozing   (snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          a, m, s, d, t;
    int            pre;
    logic          eb, es;
    logic [SW-1:0] el;
    string         name;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic eb, input logic es,
                       input logic [SW-1:0] el);
    n_chk++;
    if (buzz !== eb || snoozing !== es || snooze_left !== el) begin
      n_fail++;
      $display("FAIL %s: got buzz=%b snoozing=%b left=%0d, want buzz=%b snoozing=%b left=%0d",
               nm, buzz, snoozing, snooze_left, eb, es, el);
    end
  endtask

  task automatic cyc(input logic a, input logic m, input logic s,
                     input logic d, input logic t);
    alarm_on    = a;
    alarm_match = m;
    snooze_btn  = s;
    dismiss_btn = d;
    tick        = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic a, input logic m, input logic s);
    for (int i = 0; i < 3; i++) cyc(a, m, s, 1'b0, 1'b0);
    cyc(a, m, s, 1'b0, 1'b1);
  endtask

  task automatic add(input logic a, m, s, d, t, input int pre,
                     input logic eb, es, input logic [SW-1:0] el,
                     input string nm);
    vec_t v;
    v.a = a; v.m = m; v.s = s; v.d = d; v.t = t; v.pre = pre;
    v.eb = eb; v.es = es; v.el = el; v.name = nm;
    vt.push_back(v);
  endtask

  initial begin
    // test 1: ring, timeout, hold in DONE, re-arm
    add(1,1,0,0,0, 0, 1,0,0, "ring_start");
    add(1,1,0,0,1, 3, 1,0,0, "ring_t1");
    add(1,1,0,0,1, 3, 1,0,0, "ring_t2");
    add(1,1,0,0,1, 3, 1,0,0, "ring_t3");
    add(1,1,0,0,1, 3, 0,0,0, "ring_timeout");
    add(1,1,0,0,0, 3, 0,0,0, "done_hold");
    add(1,0,0,0,0, 0, 0,0,0, "done_to_idle");
    add(1,1,0,0,0, 0, 1,0,0, "rering");
    // test 2: snooze countdown then re-ring
    add(1,1,1,0,0, 0, 0,1,5, "snooze_enter");
    add(1,1,0,0,1, 3, 0,1,4, "snooze_4");
    add(1,1,0,0,1, 3, 0,1,3, "snooze_3");
    add(1,1,0,0,1, 3, 0,1,2, "snooze_2");
    add(1,1,0,0,1, 3, 0,1,1, "snooze_1");
    add(1,1,0,0,1, 3, 1,0,0, "snooze_expire");
    // test 3: simultaneous buttons, held snooze
    add(1,1,1,1,0, 0, 0,0,0, "both_btn");
    add(1,0,1,0,0, 0, 0,0,0, "held_idle");
    add(1,1,1,0,0, 0, 1,0,0, "held_ring");
    add(1,1,1,0,1, 3, 1,0,0, "held_no_snooze");

    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("reset_state", 0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("idle_off", 0, 0, 0);

    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].pre; k++)
        cyc(vt[i].a, vt[i].m, vt[i].s, vt[i].d, 1'b0);
      cyc(vt[i].a, vt[i].m, vt[i].s, vt[i].d, vt[i].t);
      check(vt[i].name, vt[i].eb, vt[i].es, vt[i].el);
    end

    // test 4: alarm_on dropped mid-snooze
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("t4_snooze", 0, 1, 5);
    tk(1, 1, 0);
    tk(1, 1, 0);
    check("t4_left3", 0, 1, 3);
    cyc(0, 1, 0, 0, 0);
    check("t4_off", 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("t4_rearm", 1, 0, 0);

    // test 5: async reset mid-ring
    #2 rst = 1'b0;
    #1 check("t5_async_rst", 0, 0, 0);
    @(posedge clk);
    #1 check("t5_rst_held", 0, 0, 0);
    alarm_on = 1'b1;
    alarm_match = 1'b1;
    rst = 1'b1;
    check("t5_release", 0, 0, 0);
    @(posedge clk);
    #1 check("t5_ring", 1, 0, 0);

    // test 6: snooze limit
    for (int r = 0; r < 2; r++) begin
      cyc(1, 1, 1, 0, 0);
      check("t6_snooze", 0, 1, 5);
      for (int k = 0; k < 5; k++) tk(1, 1, 0);
      check("t6_expire", 1, 0, 0);
    end
    cyc(1, 1, 1, 0, 0);
`ifdef SNOOZE_LIMIT_EN
    check("t6_third_ignored", 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("t6_still_ring", 1, 0, 0);
`else
    check("t6_third_snooze", 0, 1, 5);
    cyc(1, 1, 0, 0, 0);
    check("t6_still_snooze", 0, 1, 5);
`endif
    cyc(1, 1, 0, 1, 0);
    check("t6_dismiss", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
